hazard_ctrl: RTL

- Central hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Keeps a scoreboard of destination registers for instructions in EX and MEM.
- Issues registered forwarding selects to EX, load-use stalls, and branch/jump flushes.
- Also keeps saturating performance counters for stalls and flushes.
- Sits beside the ID stage. Its outputs drive the PC, the IF/ID register, the ID/EX register and the EX forwarding muxes.

---
 rtl/hazard_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: tracks EX/MEM destinations,
// raises load-use stalls and branch/jump flushes, and registers EX forward selects.
module hazard_ctrl #(
    parameter logic [5:0] LDW_OP  = 6'h23,
    parameter logic [5:0] JUMP_OP = 6'h02,
    parameter logic [5:0] BEQ_OP  = 6'h04,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_rwd,
    input  logic             ex_branch_taken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic [2:0]       rs_fwd,
    output logic [2:0]       rt_fwd,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic       ex_v, ex_ld, mem_v, mem_ld;
    logic [4:0] ex_rwd, mem_rwd;

    logic rs_match_ex, rt_match_ex, rs_match_mem, rt_match_mem;
    logic ld_hazard, is_jump, stall_eff, jump_flush;
    logic [2:0] rs_sel, rt_sel;

    assign rs_match_ex  = id_use_rs && id_valid && ex_v  && (ex_rwd  != 5'd0) && (id_rs == ex_rwd);
    assign rt_match_ex  = id_use_rt && id_valid && ex_v  && (ex_rwd  != 5'd0) && (id_rt == ex_rwd);
    assign rs_match_mem = id_use_rs && id_valid && mem_v && (mem_rwd != 5'd0) && (id_rs == mem_rwd);
    assign rt_match_mem = id_use_rt && id_valid && mem_v && (mem_rwd != 5'd0) && (id_rt == mem_rwd);

    assign ld_hazard = (rs_match_ex || rt_match_ex) && ex_ld;

    // Branches resolve in EX; a colliding BEQ encoding must never be mistaken for a jump.
    assign is_jump    = id_valid && (id_opcode == JUMP_OP) && (id_opcode != BEQ_OP);
    assign stall_eff  = ld_hazard && !ex_branch_taken;
    assign jump_flush = is_jump && !ex_branch_taken && !ld_hazard;

    assign rs_sel = rs_match_ex ? 3'd1 : (rs_match_mem ? 3'd2 : 3'd0);
    assign rt_sel = rt_match_ex ? 3'd1 : (rt_match_mem ? 3'd2 : 3'd0);

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        if (!rst) begin
            pc_stall     = stall_eff;
            if_id_stall  = stall_eff;
            id_ex_bubble = stall_eff || ex_branch_taken;
            flush_if_id  = ex_branch_taken || jump_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v      <= 1'b0;
            ex_rwd    <= 5'd0;
            ex_ld     <= 1'b0;
            mem_v     <= 1'b0;
            mem_rwd   <= 5'd0;
            mem_ld    <= 1'b0;
            rs_fwd    <= 3'd0;
            rt_fwd    <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            mem_v   <= ex_v;
            mem_rwd <= ex_rwd;
            mem_ld  <= ex_ld;
            if (id_ex_bubble) begin
                ex_v   <= 1'b0;
                ex_rwd <= 5'd0;
                ex_ld  <= 1'b0;
                rs_fwd <= 3'd0;
                rt_fwd <= 3'd0;
            end else begin
                ex_v   <= id_valid;
                ex_rwd <= id_rwd;
                ex_ld  <= (id_opcode == LDW_OP);
                rs_fwd <= rs_sel;
                rt_fwd <= rt_sel;
            end
            if (stall_eff && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_if_id && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
